// File: rtl/easy_multi_timer.sv
// Multi-channel interval timer on a 32-bit Avalon-MM slave: per-channel down-counter,
// 8-bit prescaler, one-shot/continuous mode, overrun detection, snapshot capture and irq.
module easy_multi_timer #(
  parameter int          NUM_CH       = 4,
  parameter int          CNT_W        = 32,
  parameter int unsigned RESET_PERIOD = 49999
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              chipselect,
  input  logic [4:0]        address,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [NUM_CH-1:0] irq_vec,
  output logic              irq
);

  localparam logic [CNT_W-1:0] RST_P = CNT_W'(RESET_PERIOD);

  // Bus handshake: a write is accepted on every edge where chipselect=1 and write_n=0;
  // reads need no strobe, readdata follows address with one clock of latency.
  logic [2:0]  ch_sel;
  logic [1:0]  reg_sel;
  logic        wr_en;
  logic [31:0] ch_rd [NUM_CH];
  logic [31:0] rd_next;

  assign ch_sel  = address[4:2];
  assign reg_sel = address[1:0];
  assign wr_en   = chipselect & ~write_n;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] snap_q;
    logic [7:0]       presc_q;
    logic [7:0]       presc_cnt_q;
    logic             ito_q;
    logic             cont_q;
    logic             run_q;
    logic             to_q;
    logic             ovr_q;
    logic             load_pend_q;

    logic sel;
    logic wr_status;
    logic wr_ctrl;
    logic wr_period;
    logic wr_snap;
    logic start;
    logic stop;
    logic tick;
    logic timeout;

    assign sel       = wr_en && (ch_sel == 3'(g));
    assign wr_status = sel && (reg_sel == 2'd0);
    assign wr_ctrl   = sel && (reg_sel == 2'd1);
    assign wr_period = sel && (reg_sel == 2'd2);
    assign wr_snap   = sel && (reg_sel == 2'd3);
    assign start     = wr_ctrl & writedata[2];
    assign stop      = wr_ctrl & writedata[3];
    assign tick      = run_q & (presc_cnt_q == presc_q);
    // The cycle that applies a pending PERIOD load takes precedence over any expiry.
    assign timeout   = tick & (cnt_q == '0) & ~load_pend_q;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        period_q    <= RST_P;
        cnt_q       <= RST_P;
        snap_q      <= '0;
        presc_q     <= '0;
        presc_cnt_q <= '0;
        ito_q       <= 1'b0;
        cont_q      <= 1'b0;
        run_q       <= 1'b0;
        to_q        <= 1'b0;
        ovr_q       <= 1'b0;
        load_pend_q <= 1'b0;
      end else begin
        load_pend_q <= wr_period;

        if (wr_period) period_q <= writedata[CNT_W-1:0];

        if (wr_ctrl) begin
          ito_q   <= writedata[0];
          cont_q  <= writedata[1];
          presc_q <= writedata[15:8];
        end

        if (wr_snap) snap_q <= cnt_q;

        // A reload coinciding with a PERIOD write picks up the value being written.
        if (load_pend_q) begin
          cnt_q <= period_q;
        end else if (tick) begin
          if (cnt_q == '0) cnt_q <= wr_period ? writedata[CNT_W-1:0] : period_q;
          else             cnt_q <= cnt_q - CNT_W'(1);
        end

        if (start || load_pend_q || !run_q || tick) presc_cnt_q <= '0;
        else                                        presc_cnt_q <= presc_cnt_q + 8'd1;

        if (start)                                                 run_q <= 1'b1;
        else if (stop || load_pend_q || (timeout && !cont_q))      run_q <= 1'b0;

        // A STATUS write racing a timeout keeps the new event visible in TO.
        if (wr_status) begin
          to_q  <= timeout;
          ovr_q <= 1'b0;
        end else if (timeout) begin
          to_q <= 1'b1;
          if (to_q) ovr_q <= 1'b1;
        end
      end
    end

    assign ch_rd[g] = (reg_sel == 2'd0) ? {29'b0, ovr_q, run_q, to_q} :
                      (reg_sel == 2'd1) ? {16'b0, presc_q, 6'b0, cont_q, ito_q} :
                      (reg_sel == 2'd2) ? 32'(period_q) :
                                          32'(snap_q);

    assign irq_vec[g] = to_q & ito_q;
  end

  always_comb begin
    rd_next = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_sel == 3'(i)) rd_next = ch_rd[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_next;
  end

  assign irq = |irq_vec;

endmodule
